// File: rtl/isa_test_sequencer.sv
// Sequences an ISA test: holds the core in reset, watches its PC for emit/end markers,
// buffers emitted characters in a FIFO and reports pass/overflow. Optional watchdog: ISA_SEQ_TIMEOUT_EN.
module isa_test_sequencer #(
   parameter logic [31:0] PC_EMIT        = 32'h14,
   parameter logic [31:0] PC_END         = 32'h1c,
   parameter int          RESET_HOLD     = 4,
   parameter int          FIFO_DEPTH     = 8,
   parameter int          TIMEOUT_CYCLES = 100000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [31:0] i_pc_debug,
   input  logic [31:0] i_io_ledr,
   output logic        o_core_reset,
   output logic        o_char_valid,
   output logic [7:0]  o_char_data,
   input  logic        i_char_ready,
   output logic [15:0] o_char_count,
   output logic        o_overflow,
   output logic        o_timeout,
   output logic        o_pass,
   output logic        o_done
);

   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam int              CW        = AW + 1;
   localparam logic [CW-1:0]   FULL_LVL  = CW'(FIFO_DEPTH);
   localparam logic [7:0]      HOLD_LAST = 8'(RESET_HOLD - 1);
   localparam logic [31:0]     TO_LIM    = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HOLD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state;
   logic [7:0]    r_hold_cnt;
   logic          r_core_reset;
   logic          r_done;
   logic          r_pass;
   logic          r_end_pc;
   logic          r_overflow;
   logic [15:0]   r_char_count;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_fill;

   logic          w_empty;
   logic          w_full;
   logic          w_start_go;
   logic          w_pc_end;
   logic          w_push_req;
   logic          w_push;
   logic          w_pop;
   logic          w_drop;
   logic          w_drain_en;
   logic          w_wdog_hit;
   logic          w_unused_ledr;

   assign w_empty    = (r_fill == '0);
   assign w_full     = (r_fill == FULL_LVL);
   assign w_start_go = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_pc_end   = (r_state == S_RUN) && (i_pc_debug == PC_END);
   // PC_END wins over a same-cycle emit match, so the emit is suppressed here.
   assign w_push_req = (r_state == S_RUN) && (i_pc_debug == PC_EMIT) && !w_pc_end;
   assign w_drain_en = (r_state != S_IDLE) && (r_state != S_HOLD);
   assign w_pop      = !w_empty && i_char_ready && w_drain_en;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;
   assign w_unused_ledr = ^i_io_ledr[31:8];

`ifdef ISA_SEQ_TIMEOUT_EN
   logic [31:0] r_wdog;
   logic        r_timeout;
   logic [31:0] w_wdog_next;

   assign w_wdog_next = r_wdog + 32'd1;
   assign w_wdog_hit  = (r_state == S_RUN) && !w_pc_end && (w_wdog_next == TO_LIM);

   // Held at zero outside RUN so every RUN entry starts a fresh count.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == S_RUN) begin
            r_wdog <= w_wdog_next;
         end else begin
            r_wdog <= '0;
         end
         if (w_start_go) begin
            r_timeout <= 1'b0;
         end else if (w_wdog_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_timeout = r_timeout;
`else
   logic w_unused_to;

   assign w_unused_to = ^TO_LIM;
   assign w_wdog_hit  = 1'b0;
   assign o_timeout   = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_hold_cnt   <= '0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_end_pc     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_core_reset <= 1'b1;
               if (i_start) begin
                  r_state    <= S_HOLD;
                  r_hold_cnt <= '0;
                  r_pass     <= 1'b0;
                  r_end_pc   <= 1'b0;
               end
            end
            S_HOLD: begin
               if (r_hold_cnt == HOLD_LAST) begin
                  r_state      <= S_RUN;
                  r_core_reset <= 1'b0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
               end
            end
            S_RUN: begin
               if (w_pc_end) begin
                  r_state      <= S_DRAIN;
                  r_core_reset <= 1'b1;
                  r_end_pc     <= 1'b1;
               end else if (w_wdog_hit) begin
                  r_state      <= S_DRAIN;
                  r_core_reset <= 1'b1;
               end
            end
            S_DRAIN: begin
               // Overflow cannot change here (no pushes), so it is final.
               if (w_empty) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_pass  <= r_end_pc && !r_overflow;
               end
            end
            S_DONE: begin
               if (i_start) begin
                  r_state    <= S_HOLD;
                  r_done     <= 1'b0;
                  r_hold_cnt <= '0;
                  r_pass     <= 1'b0;
                  r_end_pc   <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_core_reset <= 1'b1;
               r_done       <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_io_ledr[7:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fill       <= '0;
         r_overflow   <= 1'b0;
         r_char_count <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + CW'(1);
            2'b01:   r_fill <= r_fill - CW'(1);
            default: r_fill <= r_fill;
         endcase
         if (w_start_go) begin
            r_overflow   <= 1'b0;
            r_char_count <= '0;
         end else begin
            if (w_drop) begin
               r_overflow <= 1'b1;
            end
            if (w_pop && (r_char_count != 16'hFFFF)) begin
               r_char_count <= r_char_count + 16'd1;
            end
         end
      end
   end

   assign o_core_reset = r_core_reset;
   assign o_char_valid = !w_empty;
   assign o_char_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign o_char_count = r_char_count;
   assign o_overflow   = r_overflow;
   assign o_pass       = r_pass;
   assign o_done       = r_done;

endmodule

// File: tb/tb_isa_test_sequencer.sv
// Directed bench for isa_test_sequencer: hold timing, emit/drain, overflow,
// full-FIFO push+pop, watchdog (either build) and mid-run reset.
module tb_isa_test_sequencer;

   logic        clk;
   logic        i_reset;
   logic        i_start;
   logic [31:0] i_pc_debug;
   logic [31:0] i_io_ledr;
   logic        o_core_reset;
   logic        o_char_valid;
   logic [7:0]  o_char_data;
   logic        i_char_ready;
   logic [15:0] o_char_count;
   logic        o_overflow;
   logic        o_timeout;
   logic        o_pass;
   logic        o_done;

   int checks = 0;
   int errors = 0;

   isa_test_sequencer #(
      .TIMEOUT_CYCLES(50)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_pc_debug   (i_pc_debug),
      .i_io_ledr    (i_io_ledr),
      .o_core_reset (o_core_reset),
      .o_char_valid (o_char_valid),
      .o_char_data  (o_char_data),
      .i_char_ready (i_char_ready),
      .o_char_count (o_char_count),
      .o_overflow   (o_overflow),
      .o_timeout    (o_timeout),
      .o_pass       (o_pass),
      .o_done       (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_time_limit simulation did not finish in time");
      $fatal(1, "time limit");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then sit through the 4 HOLD cycles; leaves the DUT in RUN.
   task automatic go_run;
      i_pc_debug = 32'h0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
   endtask

   task automatic test_reset;
      logic [30:0] exp_v;
      i_reset = 1'b1;
      tick();
      tick();
      i_reset = 1'b0;
      exp_v = {1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
      checks++;
      if ({o_core_reset, o_char_valid, o_char_data, o_char_count, o_overflow, o_timeout, o_pass, o_done} !== exp_v) begin
         errors++;
         $display("FAIL reset_values got %h exp %h",
                  {o_core_reset, o_char_valid, o_char_data, o_char_count, o_overflow, o_timeout, o_pass, o_done}, exp_v);
      end
      tick();
      checks++;
      if (o_core_reset !== 1'b1) begin
         errors++;
         $display("FAIL idle_core_reset got %b exp 1", o_core_reset);
      end
   endtask

   task automatic test_hold;
      i_pc_debug = 32'h0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_core_reset !== 1'b1) begin
            errors++;
            $display("FAIL hold_cycle_%0d core_reset got %b exp 1", k, o_core_reset);
         end
         tick();
      end
      checks++;
      if (o_core_reset !== 1'b0) begin
         errors++;
         $display("FAIL run_core_reset got %b exp 0", o_core_reset);
      end
   endtask

   // Continues in RUN from test_hold.
   task automatic test_emit;
      i_char_ready = 1'b1;
      i_pc_debug = 32'h10;
      tick();
      i_pc_debug = 32'h14;
      i_io_ledr = 32'hABCD_EF41;
      checks++;
      if (o_char_valid !== 1'b0) begin
         errors++;
         $display("FAIL emit_no_comb_path valid got %b exp 0", o_char_valid);
      end
      tick();
      checks++;
      if ({o_char_valid, o_char_data} !== {1'b1, 8'h41}) begin
         errors++;
         $display("FAIL emit_char0 valid/data got %b/%h exp 1/41", o_char_valid, o_char_data);
      end
      i_pc_debug = 32'h18;
      tick();
      checks++;
      if ({o_char_valid, o_char_count} !== {1'b0, 16'd1}) begin
         errors++;
         $display("FAIL emit_pop0 valid/count got %b/%0d exp 0/1", o_char_valid, o_char_count);
      end
      i_pc_debug = 32'h14;
      i_io_ledr = 32'h0000_0042;
      tick();
      checks++;
      if ({o_char_valid, o_char_data} !== {1'b1, 8'h42}) begin
         errors++;
         $display("FAIL emit_char1 valid/data got %b/%h exp 1/42", o_char_valid, o_char_data);
      end
      i_pc_debug = 32'h1c;
      tick();
      checks++;
      if ({o_core_reset, o_done, o_char_count} !== {1'b1, 1'b0, 16'd2}) begin
         errors++;
         $display("FAIL emit_drain core_reset/done/count got %b/%b/%0d exp 1/0/2", o_core_reset, o_done, o_char_count);
      end
      i_pc_debug = 32'h0;
      tick();
      checks++;
      if ({o_done, o_pass, o_char_count, o_char_valid} !== {1'b1, 1'b1, 16'd2, 1'b0}) begin
         errors++;
         $display("FAIL emit_done done/pass/count/valid got %b/%b/%0d/%b exp 1/1/2/0",
                  o_done, o_pass, o_char_count, o_char_valid);
      end
   endtask

   task automatic test_overflow;
      i_char_ready = 1'b0;
      i_pc_debug = 32'h0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++;
      if ({o_char_count, o_pass, o_done} !== {16'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL restart_clear count/pass/done got %0d/%b/%b exp 0/0/0", o_char_count, o_pass, o_done);
      end
      for (int k = 0; k < 4; k++) tick();
      for (int j = 0; j < 9; j++) begin
         i_pc_debug = 32'h14;
         i_io_ledr = 32'h50 + j;
         tick();
      end
      checks++;
      if ({o_overflow, o_char_valid, o_char_data} !== {1'b1, 1'b1, 8'h50}) begin
         errors++;
         $display("FAIL ovf_flag ovf/valid/data got %b/%b/%h exp 1/1/50", o_overflow, o_char_valid, o_char_data);
      end
      i_pc_debug = 32'h1c;
      tick();
      i_pc_debug = 32'h0;
      i_char_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         checks++;
         if ({o_char_valid, o_char_data} !== {1'b1, 8'(8'h50 + j)}) begin
            errors++;
            $display("FAIL ovf_order_%0d valid/data got %b/%h exp 1/%h", j, o_char_valid, o_char_data, 8'(8'h50 + j));
         end
         tick();
      end
      checks++;
      if ({o_char_valid, o_done} !== 2'b00) begin
         errors++;
         $display("FAIL ovf_empty valid/done got %b/%b exp 0/0", o_char_valid, o_done);
      end
      tick();
      checks++;
      if ({o_done, o_pass, o_overflow, o_char_count} !== {1'b1, 1'b0, 1'b1, 16'd8}) begin
         errors++;
         $display("FAIL ovf_done done/pass/ovf/count got %b/%b/%b/%0d exp 1/0/1/8",
                  o_done, o_pass, o_overflow, o_char_count);
      end
   endtask

   task automatic test_full_push_pop;
      i_char_ready = 1'b0;
      go_run();
      for (int j = 0; j < 8; j++) begin
         i_pc_debug = 32'h14;
         i_io_ledr = 32'h60 + j;
         tick();
      end
      i_pc_debug = 32'h14;
      i_io_ledr = 32'h68;
      i_char_ready = 1'b1;
      tick();
      checks++;
      if ({o_overflow, o_char_data} !== {1'b0, 8'h61}) begin
         errors++;
         $display("FAIL full_pushpop ovf/data got %b/%h exp 0/61", o_overflow, o_char_data);
      end
      i_pc_debug = 32'h0;
      i_char_ready = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      checks++;
      if ({o_core_reset, o_overflow} !== 2'b00) begin
         errors++;
         $display("FAIL start_ignored_run core_reset/ovf got %b/%b exp 0/0", o_core_reset, o_overflow);
      end
      i_pc_debug = 32'h1c;
      tick();
      i_pc_debug = 32'h0;
      i_char_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         checks++;
         if ({o_char_valid, o_char_data} !== {1'b1, 8'(8'h61 + j)}) begin
            errors++;
            $display("FAIL full_order_%0d valid/data got %b/%h exp 1/%h", j, o_char_valid, o_char_data, 8'(8'h61 + j));
         end
         tick();
      end
      checks++;
      if (o_char_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_occupancy valid got %b exp 0", o_char_valid);
      end
      tick();
      checks++;
      if ({o_done, o_pass, o_char_count} !== {1'b1, 1'b1, 16'd9}) begin
         errors++;
         $display("FAIL full_done done/pass/count got %b/%b/%0d exp 1/1/9", o_done, o_pass, o_char_count);
      end
   endtask

   task automatic test_timeout;
      i_char_ready = 1'b1;
      go_run();
`ifdef ISA_SEQ_TIMEOUT_EN
      for (int k = 0; k < 49; k++) tick();
      checks++;
      if ({o_timeout, o_core_reset} !== 2'b00) begin
         errors++;
         $display("FAIL wdog_early timeout/core_reset got %b/%b exp 0/0", o_timeout, o_core_reset);
      end
      tick();
      checks++;
      if ({o_timeout, o_core_reset} !== 2'b11) begin
         errors++;
         $display("FAIL wdog_fire timeout/core_reset got %b/%b exp 1/1", o_timeout, o_core_reset);
      end
      tick();
      checks++;
      if ({o_done, o_pass, o_timeout} !== 3'b101) begin
         errors++;
         $display("FAIL wdog_done done/pass/timeout got %b/%b/%b exp 1/0/1", o_done, o_pass, o_timeout);
      end
`else
      for (int k = 0; k < 1000; k++) tick();
      checks++;
      if ({o_core_reset, o_done, o_timeout} !== 3'b000) begin
         errors++;
         $display("FAIL no_wdog_run core_reset/done/timeout got %b/%b/%b exp 0/0/0", o_core_reset, o_done, o_timeout);
      end
      i_pc_debug = 32'h1c;
      tick();
      i_pc_debug = 32'h0;
      tick();
      checks++;
      if ({o_done, o_pass} !== 2'b11) begin
         errors++;
         $display("FAIL no_wdog_done done/pass got %b/%b exp 1/1", o_done, o_pass);
      end
`endif
   endtask

   task automatic test_reset_mid_run;
      i_char_ready = 1'b1;
      go_run();
      i_pc_debug = 32'h14;
      i_io_ledr = 32'h71;
      tick();
      i_pc_debug = 32'h0;
      tick();
      i_char_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         i_pc_debug = 32'h14;
         i_io_ledr = 32'h80 + j;
         tick();
      end
      i_pc_debug = 32'h0;
      checks++;
      if ({o_char_valid, o_char_data, o_char_count} !== {1'b1, 8'h80, 16'd1}) begin
         errors++;
         $display("FAIL midrun_buffered valid/data/count got %b/%h/%0d exp 1/80/1", o_char_valid, o_char_data, o_char_count);
      end
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      checks++;
      if ({o_char_valid, o_char_data, o_char_count, o_core_reset, o_done} !== {1'b0, 8'h00, 16'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL midrun_reset valid/data/count/core_reset/done got %b/%h/%0d/%b/%b exp 0/00/0/1/0",
                  o_char_valid, o_char_data, o_char_count, o_core_reset, o_done);
      end
      i_char_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if ({o_core_reset, o_char_valid, o_char_count} !== {1'b1, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL midrun_idle core_reset/valid/count got %b/%b/%0d exp 1/0/0", o_core_reset, o_char_valid, o_char_count);
      end
   endtask

   initial begin
      i_reset      = 1'b1;
      i_start      = 1'b0;
      i_pc_debug   = 32'h0;
      i_io_ledr    = 32'h0;
      i_char_ready = 1'b0;
      test_reset();
      test_hold();
      test_emit();
      test_overflow();
      test_full_push_pop();
      test_timeout();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
